// File: rtl/seq_4cross4_mul_ctrl.sv
// ============================================================================
//  Module   : seq_4cross4_mul_ctrl
//  Brief    : Serial 4x4 unsigned multiplier reusing one exact 2x2 cell.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module exactOutput_2cross2 (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);
    assign p_o = {2'b00, a_i} * {2'b00, b_i};
endmodule

module seq_4cross4_mul_ctrl #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] result,
    output logic       busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  a_q, b_q;
    logic [7:0]  acc_q;
    logic [3:0]  mask_q;
    logic        out_valid_q;
    logic [7:0]  result_q;

    logic [3:0]  mask_load_d;
    logic [1:0]  step_d;
    logic [1:0]  op_a_d, op_b_d;
    logic [2:0]  shift_d;
    logic [3:0]  pp_d;
    logic [7:0]  acc_d;
    logic [3:0]  mask_d;

    // Step k is worth running only when neither 2-bit sub-operand is zero.
    always_comb begin
        mask_load_d = 4'hF;
        if (SKIP_ZERO) begin
            mask_load_d[0] = (a[1:0] != 2'b00) && (b[1:0] != 2'b00);
            mask_load_d[1] = (a[1:0] != 2'b00) && (b[3:2] != 2'b00);
            mask_load_d[2] = (a[3:2] != 2'b00) && (b[1:0] != 2'b00);
            mask_load_d[3] = (a[3:2] != 2'b00) && (b[3:2] != 2'b00);
        end
    end

    always_comb begin
        step_d = 2'd0;
        if (mask_q[0])      step_d = 2'd0;
        else if (mask_q[1]) step_d = 2'd1;
        else if (mask_q[2]) step_d = 2'd2;
        else if (mask_q[3]) step_d = 2'd3;
    end

    always_comb begin
        op_a_d  = step_d[1] ? a_q[3:2] : a_q[1:0];
        op_b_d  = step_d[0] ? b_q[3:2] : b_q[1:0];
        shift_d = {1'b0, step_d[1], 1'b0} + {1'b0, step_d[0], 1'b0};
    end

    exactOutput_2cross2 u_cell (
        .a_i (op_a_d),
        .b_i (op_b_d),
        .p_o (pp_d)
    );

    assign acc_d  = acc_q + ({4'b0000, pp_d} << shift_d);
    assign mask_d = mask_q & ~(4'b0001 << step_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            acc_q       <= 8'd0;
            mask_q      <= 4'd0;
            out_valid_q <= 1'b0;
            result_q    <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= b;
                        acc_q  <= 8'd0;
                        mask_q <= mask_load_d;
                        if (mask_load_d == 4'd0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= 8'd0;
                        end else begin
                            state_q <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc_q  <= acc_d;
                    mask_q <= mask_d;
                    if (mask_d == 4'd0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= acc_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q == MUL) || (state_q == DONE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_4cross4_mul_ctrl.sv
// ============================================================================
//  Module   : tb_seq_4cross4_mul_ctrl
//  Brief    : Directed and exhaustive checks for both SKIP_ZERO settings.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_4cross4_mul_ctrl;
    logic       clk;
    logic       rst;
    logic       in_valid_s  [2];
    logic       in_ready_s  [2];
    logic [3:0] a_s         [2];
    logic [3:0] b_s         [2];
    logic       out_valid_s [2];
    logic       out_ready_s [2];
    logic [7:0] result_s    [2];
    logic       busy_s      [2];

    int checks;
    int failures;

    // Index 0: all steps always run; index 1: zero steps skipped.
    seq_4cross4_mul_ctrl #(.SKIP_ZERO(1'b0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_s[0]),
        .in_ready  (in_ready_s[0]),
        .a         (a_s[0]),
        .b         (b_s[0]),
        .out_valid (out_valid_s[0]),
        .out_ready (out_ready_s[0]),
        .result    (result_s[0]),
        .busy      (busy_s[0])
    );

    seq_4cross4_mul_ctrl #(.SKIP_ZERO(1'b1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_s[1]),
        .in_ready  (in_ready_s[1]),
        .a         (a_s[1]),
        .b         (b_s[1]),
        .out_valid (out_valid_s[1]),
        .out_ready (out_ready_s[1]),
        .result    (result_s[1]),
        .busy      (busy_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_steps(input int d, input logic [3:0] av, input logic [3:0] bv);
        int n;
        if (d == 0) return 4;
        n = 0;
        if (av[1:0] != 0 && bv[1:0] != 0) n++;
        if (av[1:0] != 0 && bv[3:2] != 0) n++;
        if (av[3:2] != 0 && bv[1:0] != 0) n++;
        if (av[3:2] != 0 && bv[3:2] != 0) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on DUT d with a DONE stall of 'stall' cycles.
    task automatic run_op(input int d, input logic [3:0] av, input logic [3:0] bv,
                          input int stall);
        int lat;
        int p;
        int prod;
        int r0;
        p    = exp_steps(d, av, bv);
        prod = int'(av) * int'(bv);
        check_eq("rdy_before_accept", int'(in_ready_s[d]), 1);
        a_s[d]         = av;
        b_s[d]         = bv;
        in_valid_s[d]  = 1'b1;
        out_ready_s[d] = 1'b0;
        tick();
        in_valid_s[d] = 1'b0;
        lat = 0;
        while (!out_valid_s[d] && lat < 8) begin
            check_eq("rdy_low_in_mul", int'(in_ready_s[d]), 0);
            tick();
            lat++;
        end
        check_eq("latency", lat, p);
        check_eq("busy_in_done", int'(busy_s[d]), 1);
        check_eq("rdy_low_in_done", int'(in_ready_s[d]), 0);
        check_eq("product", int'(result_s[d]), prod);
        r0 = int'(result_s[d]);
        for (int i = 0; i < stall; i++) begin
            in_valid_s[d] = i[0];
            a_s[d]        = ~av;
            b_s[d]        = ~bv;
            tick();
            check_eq("hold_valid", int'(out_valid_s[d]), 1);
            check_eq("hold_result", int'(result_s[d]), r0);
        end
        in_valid_s[d]  = 1'b0;
        out_ready_s[d] = 1'b1;
        tick();
        out_ready_s[d] = 1'b0;
        check_eq("valid_drop", int'(out_valid_s[d]), 0);
        check_eq("rdy_after_hs", int'(in_ready_s[d]), 1);
        check_eq("idle_not_busy", int'(busy_s[d]), 0);
    endtask

    initial begin
        int lat;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid_s[d]  = 1'b0;
            out_ready_s[d] = 1'b0;
            a_s[d]         = 4'd0;
            b_s[d]         = 4'd0;
        end
        #2;
        check_eq("rst_in_ready", int'(in_ready_s[1]), 0);
        check_eq("rst_out_valid", int'(out_valid_s[1]), 0);
        check_eq("rst_result", int'(result_s[1]), 0);
        check_eq("rst_busy", int'(busy_s[0]), 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_eq("rdy_after_rst", int'(in_ready_s[1]), 1);
        tick();

        run_op(1, 4'd15, 4'd15, 0);
        run_op(1, 4'b0011, 4'b0100, 0);
        run_op(0, 4'b0011, 4'b0100, 0);
        run_op(1, 4'd7, 4'd9, 6);

        // Zero product, with the next request already waiting during DONE.
        a_s[1] = 4'd0;
        b_s[1] = 4'd9;
        in_valid_s[1] = 1'b1;
        tick();
        check_eq("zero_lat0_valid", int'(out_valid_s[1]), 1);
        check_eq("zero_result", int'(result_s[1]), 0);
        a_s[1] = 4'd2;
        b_s[1] = 4'd3;
        out_ready_s[1] = 1'b1;
        tick();
        out_ready_s[1] = 1'b0;
        check_eq("no_accept_on_hs", int'(busy_s[1]), 0);
        check_eq("rdy_after_zero_hs", int'(in_ready_s[1]), 1);
        tick();
        in_valid_s[1] = 1'b0;
        check_eq("held_req_accepted", int'(busy_s[1]), 1);
        lat = 0;
        while (!out_valid_s[1] && lat < 8) begin
            tick();
            lat++;
        end
        check_eq("held_req_latency", lat, 1);
        check_eq("held_req_result", int'(result_s[1]), 6);
        out_ready_s[1] = 1'b1;
        tick();
        out_ready_s[1] = 1'b0;

        // Abort in the middle of MUL.
        a_s[1] = 4'd13;
        b_s[1] = 4'd11;
        in_valid_s[1] = 1'b1;
        tick();
        in_valid_s[1] = 1'b0;
        tick();
        tick();
        check_eq("mid_still_busy", int'(busy_s[1]), 1);
        rst = 1'b1;
        #1;
        check_eq("abort_valid", int'(out_valid_s[1]), 0);
        check_eq("abort_result", int'(result_s[1]), 0);
        check_eq("abort_busy", int'(busy_s[1]), 0);
        check_eq("abort_acc", int'(u_dut1.acc_q), 0);
        tick();
        rst = 1'b0;
        out_ready_s[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("no_stale_valid", int'(out_valid_s[1]), 0);
            check_eq("no_stale_result", int'(result_s[1]), 0);
        end
        out_ready_s[1] = 1'b0;
        run_op(1, 4'd5, 4'd5, 0);

        for (int d = 0; d < 2; d++) begin
            for (int x = 0; x < 256; x++) begin
                logic [7:0] v;
                v = x[7:0];
                run_op(d, v[7:4], v[3:0], int'($urandom_range(0, 3)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
